// File: rtl/spi_regfile_periph.sv
// -----------------------------------------------------------------------------
// spi_regfile_periph
// SPI mode-0 peripheral that drives a bank of NUM_REGS control registers,
// each DATA_W bits wide. Frames are MSB first: R/W bit (1 = write), ADDR_W
// address bits, DATA_W data bits. Writes commit on the synchronised nCS rise.
// Reads return the addressed register on cipo, one bit per SCLK fall.
//
// Optional feature macro: SPI_ERRCNT_EN
//   defined   : err_count counts aborted frames (saturating at 8'hFF), is
//               readable at address NUM_REGS, and is cleared by a write frame
//               to address NUM_REGS.
//   undefined : err_count is tied to 0 and address NUM_REGS is invalid.
//
// Ports
//   clk        in   system clock
//   rst_n      in   asynchronous active-low reset
//   nCS        in   chip select, active low, asynchronous
//   SCLK       in   SPI clock, idle low, asynchronous
//   copi       in   controller-out data, sampled on SCLK rise
//   cipo       out  controller-in data, updated on SCLK fall
//   cipo_oe    out  cipo pad output enable
//   regs_flat  out  register bank, reg i = [i*DATA_W +: DATA_W]
//   wr_strobe  out  one-cycle pulse per register on commit
//   err_count  out  aborted-frame counter
// -----------------------------------------------------------------------------
module spi_regfile_periph #(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         nCS,
    input  logic                         SCLK,
    input  logic                         copi,
    output logic                         cipo,
    output logic                         cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0]   regs_flat,
    output logic [NUM_REGS-1:0]          wr_strobe,
    output logic [7:0]                   err_count
);

    localparam int FRAME = 1 + ADDR_W + DATA_W;
    localparam int CNT_W = $clog2(FRAME + 1);
    localparam int RX_W  = ADDR_W + DATA_W;

    localparam logic [CNT_W-1:0]  FRAME_C    = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0]  HDR_LAST_C = CNT_W'(ADDR_W);
    localparam logic [CNT_W-1:0]  ONE_C      = CNT_W'(1);
    localparam logic [ADDR_W-1:0] NUM_REGS_A = ADDR_W'(NUM_REGS);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CMD  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    // Synchroniser chains plus the edge-detect flops
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic                   r_ncs_edge;
    logic                   r_sclk_edge;

    logic w_ncs_s, w_sclk_s, w_copi_s;
    logic w_ncs_rise, w_ncs_fall, w_sclk_rise, w_sclk_fall;

    // Framing state
    logic [1:0]                r_state, w_state_n;
    logic [CNT_W-1:0]          r_cnt, w_cnt_n, w_cnt_inc;
    logic [RX_W-1:0]           r_rx_shift, w_rx_n, w_rx_next;
    logic                      r_rw, w_rw_n;
    logic [ADDR_W-1:0]         r_addr, w_addr_n;
    logic [DATA_W-1:0]         r_tx_shift, w_tx_n;
    logic                      r_cipo, w_cipo_n;
    logic                      r_cipo_oe, w_oe_n;
    logic                      w_commit;

    // Register bank
    logic [NUM_REGS*DATA_W-1:0] r_regs;
    logic [NUM_REGS-1:0]        r_wr_strobe;
    logic [DATA_W-1:0]          w_rd_val;
    logic [ADDR_W-1:0]          w_hdr_addr;
    logic                       w_hdr_rw;

    assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];
    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s = r_copi_sync[SYNC_STAGES-1];

    assign w_ncs_rise  =  w_ncs_s  & ~r_ncs_edge;
    assign w_ncs_fall  = ~w_ncs_s  &  r_ncs_edge;
    assign w_sclk_rise =  w_sclk_s & ~r_sclk_edge;
    assign w_sclk_fall = ~w_sclk_s &  r_sclk_edge;

    // The newest copi bit enters at the LSB; the header is complete once
    // ADDR_W+1 bits have arrived, so rw sits just above the address field.
    assign w_rx_next  = (r_rx_shift << 1'b1) | {{(RX_W-1){1'b0}}, w_copi_s};
    assign w_hdr_rw   = w_rx_next[ADDR_W];
    assign w_hdr_addr = w_rx_next[ADDR_W-1:0];
    assign w_cnt_inc  = (r_cnt == FRAME_C) ? r_cnt : (r_cnt + ONE_C);

    // Pin synchronisers and edge-detect flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ncs_sync  <= {SYNC_STAGES{1'b0}};
            r_sclk_sync <= {SYNC_STAGES{1'b0}};
            r_copi_sync <= {SYNC_STAGES{1'b0}};
            r_ncs_edge  <= 1'b0;
            r_sclk_edge <= 1'b0;
        end else begin
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], nCS};
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], SCLK};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], copi};
            r_ncs_edge  <= w_ncs_s;
            r_sclk_edge <= w_sclk_s;
        end
    end

    // Read-data mux for the address just decoded from the header
    always_comb begin
        w_rd_val = {DATA_W{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_hdr_addr == ADDR_W'(i)) begin
                w_rd_val = r_regs[i*DATA_W +: DATA_W];
            end else begin
                w_rd_val = w_rd_val;
            end
        end
`ifdef SPI_ERRCNT_EN
        if (w_hdr_addr == NUM_REGS_A) begin
            w_rd_val = DATA_W'(err_count);
        end else begin
            w_rd_val = w_rd_val;
        end
`endif
    end

    // Next-state logic: nCS rise beats everything (a coincident SCLK rise is
    // dropped), and nCS fall restarts framing from any state.
    always_comb begin
        w_state_n = r_state;
        w_cnt_n   = r_cnt;
        w_rx_n    = r_rx_shift;
        w_rw_n    = r_rw;
        w_addr_n  = r_addr;
        w_tx_n    = r_tx_shift;
        w_cipo_n  = r_cipo;
        w_commit  = 1'b0;
        if (w_ncs_rise) begin
            w_state_n = S_IDLE;
            if ((r_state == S_DONE) && r_rw && (r_addr < NUM_REGS_A)) begin
                w_commit = 1'b1;
            end else begin
                w_commit = 1'b0;
            end
        end else if (w_ncs_fall) begin
            w_state_n = S_CMD;
            w_cnt_n   = {CNT_W{1'b0}};
            w_rx_n    = {RX_W{1'b0}};
            w_rw_n    = 1'b0;
            w_addr_n  = {ADDR_W{1'b0}};
            w_tx_n    = {DATA_W{1'b0}};
        end else begin
            case (r_state)
                S_CMD: begin
                    if (w_sclk_rise) begin
                        w_rx_n  = w_rx_next;
                        w_cnt_n = w_cnt_inc;
                        if (r_cnt == HDR_LAST_C) begin
                            w_state_n = S_DATA;
                            w_rw_n    = w_hdr_rw;
                            w_addr_n  = w_hdr_addr;
                            w_tx_n    = w_hdr_rw ? {DATA_W{1'b0}} : w_rd_val;
                        end else begin
                            w_state_n = S_CMD;
                        end
                    end else begin
                        w_state_n = S_CMD;
                    end
                end
                S_DATA: begin
                    if (w_sclk_rise) begin
                        w_rx_n    = w_rx_next;
                        w_cnt_n   = w_cnt_inc;
                        w_state_n = (w_cnt_inc == FRAME_C) ? S_DONE : S_DATA;
                    end else if (w_sclk_fall && !r_rw) begin
                        w_cipo_n = r_tx_shift[DATA_W-1];
                        w_tx_n   = r_tx_shift << 1'b1;
                    end else begin
                        w_state_n = S_DATA;
                    end
                end
                S_DONE:  w_state_n = S_DONE;
                S_IDLE:  w_state_n = S_IDLE;
                default: w_state_n = S_IDLE;
            endcase
        end
        // Pad drives only while a read frame is in its data phase or finished
        // but still selected; otherwise cipo is parked low.
        w_oe_n = ((w_state_n == S_DATA) || (w_state_n == S_DONE)) && !w_rw_n;
        if (!w_oe_n) begin
            w_cipo_n = 1'b0;
        end else begin
            w_cipo_n = w_cipo_n;
        end
    end

    // Framing state registers and cipo pad outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= {CNT_W{1'b0}};
            r_rx_shift <= {RX_W{1'b0}};
            r_rw       <= 1'b0;
            r_addr     <= {ADDR_W{1'b0}};
            r_tx_shift <= {DATA_W{1'b0}};
            r_cipo     <= 1'b0;
            r_cipo_oe  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cnt      <= w_cnt_n;
            r_rx_shift <= w_rx_n;
            r_rw       <= w_rw_n;
            r_addr     <= w_addr_n;
            r_tx_shift <= w_tx_n;
            r_cipo     <= w_cipo_n;
            r_cipo_oe  <= w_oe_n;
        end
    end

    // Register bank update and per-register write strobes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_regs      <= {(NUM_REGS*DATA_W){1'b0}};
            r_wr_strobe <= {NUM_REGS{1'b0}};
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (w_commit && (r_addr == ADDR_W'(i))) begin
                    r_regs[i*DATA_W +: DATA_W] <= r_rx_shift[DATA_W-1:0];
                    r_wr_strobe[i]             <= 1'b1;
                end else begin
                    r_wr_strobe[i]             <= 1'b0;
                end
            end
        end
    end

`ifdef SPI_ERRCNT_EN
    logic [7:0] r_err_count;
    logic       w_abort;
    logic       w_err_clr;

    // A frame is aborted if nCS rises before the full frame was clocked in
    assign w_abort   = w_ncs_rise && ((r_state == S_CMD) ||
                       ((r_state == S_DATA) && (r_cnt < FRAME_C)));
    assign w_err_clr = w_ncs_rise && (r_state == S_DONE) && r_rw &&
                       (r_addr == NUM_REGS_A);

    // Saturating aborted-frame counter, cleared by a write to its address
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err_count <= 8'h00;
        end else if (w_err_clr) begin
            r_err_count <= 8'h00;
        end else if (w_abort && (r_err_count != 8'hFF)) begin
            r_err_count <= r_err_count + 8'h01;
        end else begin
            r_err_count <= r_err_count;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = 8'h00;
`endif

    assign regs_flat = r_regs;
    assign wr_strobe = r_wr_strobe;
    assign cipo      = r_cipo;
    assign cipo_oe   = r_cipo_oe;

endmodule
